// File: rtl/board_writer_if.sv
// Piece-lock request and playfield status bundle for board_writer.
// The writer (slave) owns the board array and the lock status outputs.
interface board_writer_if;
    logic       lock_req;
    logic       clear_board;
    logic [4:0] x0, x1, x2, x3;
    logic [5:0] y0, y1, y2, y3;
    logic [9:0] board [20];
    logic       busy;
    logic       done;
    logic [2:0] lines_cleared;
    logic [9:0] lines_total;
    logic       game_over;

    modport master (
        output lock_req, clear_board,
        output x0, x1, x2, x3, y0, y1, y2, y3,
        input  board, busy, done,
        input  lines_cleared, lines_total, game_over
    );

    modport slave (
        input  lock_req, clear_board,
        input  x0, x1, x2, x3, y0, y1, y2, y3,
        output board, busy, done,
        output lines_cleared, lines_total, game_over
    );
endinterface

// File: rtl/board_writer.sv
// Locks a 4-cell piece into the 10x20 playfield, then scans bottom-up
// and collapses every full row, rescanning a row after each shift.
module board_writer (
    input  logic         clk,
    input  logic         reset_n,
    board_writer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOCK, S_SCAN, S_SHIFT, S_DONE
    } state_t;

    state_t      r_state, w_next;
    logic [9:0]  r_board [20];
    logic [4:0]  r_x [4];
    logic [5:0]  r_y [4];
    logic [4:0]  r_row;
    logic [2:0]  r_cnt;
    logic [2:0]  r_lines;
    logic [9:0]  r_total;
    logic        r_over;

    logic [9:0]  w_lock_board [20];
    logic        w_lock_err;
    logic [3:0]  w_xi [4];
    logic [4:0]  w_yi [4];
    logic        w_row_full;
    logic [10:0] w_sum;

    // Collisions use the pre-lock board, so duplicate cells never collide.
    always_comb begin
        w_lock_board = r_board;
        w_lock_err   = 1'b0;
        for (int c = 0; c < 4; c++) begin
            w_xi[c] = r_x[c][3:0];
            w_yi[c] = r_y[c][4:0];
            if (r_x[c] > 5'd9 || r_y[c] > 6'd19) begin
                w_lock_err = 1'b1;
            end else begin
                if (r_board[w_yi[c]][w_xi[c]]) w_lock_err = 1'b1;
                w_lock_board[w_yi[c]][w_xi[c]] = 1'b1;
            end
        end
    end

    assign w_row_full = (r_board[r_row] == 10'h3FF);
    assign w_sum      = {1'b0, r_total} + {8'd0, r_cnt};

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (bus.lock_req) w_next = S_LOCK;
            S_LOCK:  w_next = S_SCAN;
            S_SCAN: begin
                if (w_row_full)         w_next = S_SHIFT;
                else if (r_row == 5'd0) w_next = S_DONE;
            end
            S_SHIFT: w_next = S_SCAN;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 20; i++) r_board[i] <= '0;
            for (int c = 0; c < 4; c++) begin
                r_x[c] <= '0;
                r_y[c] <= '0;
            end
            r_row   <= '0;
            r_cnt   <= '0;
            r_lines <= '0;
            r_total <= '0;
            r_over  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.lock_req) begin
                        r_x[0] <= bus.x0;
                        r_x[1] <= bus.x1;
                        r_x[2] <= bus.x2;
                        r_x[3] <= bus.x3;
                        r_y[0] <= bus.y0;
                        r_y[1] <= bus.y1;
                        r_y[2] <= bus.y2;
                        r_y[3] <= bus.y3;
                    end else if (bus.clear_board) begin
                        for (int i = 0; i < 20; i++) r_board[i] <= '0;
                        r_lines <= '0;
                        r_total <= '0;
                        r_over  <= 1'b0;
                    end
                end
                S_LOCK: begin
                    r_board <= w_lock_board;
                    if (w_lock_err) r_over <= 1'b1;
                    r_row <= 5'd19;
                    r_cnt <= '0;
                end
                S_SCAN: begin
                    if (!w_row_full && r_row != 5'd0) r_row <= r_row - 5'd1;
                end
                S_SHIFT: begin
                    for (int i = 1; i < 20; i++) begin
                        if (5'(i) <= r_row) r_board[i] <= r_board[i-1];
                    end
                    r_board[0] <= '0;
                    r_cnt <= r_cnt + 3'd1;
                end
                S_DONE: begin
                    r_lines <= r_cnt;
                    r_total <= w_sum[10] ? 10'h3FF : w_sum[9:0];
                end
                default: ;
            endcase
        end
    end

    assign bus.board         = r_board;
    assign bus.busy          = (r_state != S_IDLE);
    assign bus.done          = (r_state == S_DONE);
    assign bus.lines_cleared = r_lines;
    assign bus.lines_total   = r_total;
    assign bus.game_over     = r_over;
endmodule

// File: tb/tb_board_writer.sv
// Directed bench for board_writer: lock, line clears, collisions,
// ignored requests while busy and mid-operation reset.
module tb_board_writer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int checks = 0;
    int errors = 0;

    board_writer_if bw ();

    board_writer u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bw)
    );

    always #5 clk = ~clk;

    function automatic logic [199:0] flat_board();
        logic [199:0] f;
        f = '0;
        for (int r = 0; r < 20; r++) f[r*10 +: 10] = bw.board[r];
        return f;
    endfunction

    function automatic logic [199:0] at(int r, logic [9:0] v);
        return 200'(v) << (r * 10);
    endfunction

    task automatic set_cells(int ax0, int ay0, int ax1, int ay1,
                             int ax2, int ay2, int ax3, int ay3);
        bw.x0 = 5'(ax0); bw.y0 = 6'(ay0);
        bw.x1 = 5'(ax1); bw.y1 = 6'(ay1);
        bw.x2 = 5'(ax2); bw.y2 = 6'(ay2);
        bw.x3 = 5'(ax3); bw.y3 = 6'(ay3);
    endtask

    // lat = edges after the sampling edge until done is seen; -1 on timeout
    task automatic do_lock(int ax0, int ay0, int ax1, int ay1,
                           int ax2, int ay2, int ax3, int ay3,
                           output int lat);
        @(negedge clk);
        set_cells(ax0, ay0, ax1, ay1, ax2, ay2, ax3, ay3);
        bw.lock_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bw.lock_req = 1'b0;
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (bw.done) begin
                lat = n;
                break;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fill_row9(int r);
        int lat;
        do_lock(0, r, 1, r, 2, r, 3, r, lat);
        do_lock(4, r, 5, r, 6, r, 7, r, lat);
        do_lock(8, r, 8, r, 8, r, 8, r, lat);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bw.busy !== 1'b0 || bw.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags busy=%b done=%b want 0 0",
                     bw.busy, bw.done);
        end
        checks++;
        if (flat_board() !== '0) begin
            errors++;
            $display("FAIL reset_board got %h want 0", flat_board());
        end
        checks++;
        if (bw.lines_cleared !== 3'd0 || bw.lines_total !== 10'd0 ||
            bw.game_over !== 1'b0) begin
            errors++;
            $display("FAIL reset_status lc=%0d lt=%0d go=%b want 0 0 0",
                     bw.lines_cleared, bw.lines_total, bw.game_over);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_basic_lock();
        int lat;
        do_lock(0, 19, 1, 19, 2, 19, 3, 19, lat);
        checks++;
        if (lat !== 21) begin
            errors++;
            $display("FAIL basic_latency got %0d want 21", lat);
        end
        checks++;
        if (flat_board() !== at(19, 10'h00F)) begin
            errors++;
            $display("FAIL basic_board got %h want %h",
                     flat_board(), at(19, 10'h00F));
        end
        checks++;
        if (bw.lines_cleared !== 3'd0 || bw.game_over !== 1'b0 ||
            bw.done !== 1'b0 || bw.busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_status lc=%0d go=%b done=%b busy=%b want 0 0 0 0",
                     bw.lines_cleared, bw.game_over, bw.done, bw.busy);
        end
    endtask

    task automatic test_single_clear();
        int lat;
        do_lock(4, 19, 5, 19, 4, 19, 5, 19, lat);
        checks++;
        if (flat_board() !== at(19, 10'h03F) || bw.game_over !== 1'b0) begin
            errors++;
            $display("FAIL dup_cells board=%h go=%b want %h 0",
                     flat_board(), bw.game_over, at(19, 10'h03F));
        end
        do_lock(6, 19, 7, 19, 8, 19, 9, 19, lat);
        checks++;
        if (lat !== 23) begin
            errors++;
            $display("FAIL single_latency got %0d want 23", lat);
        end
        checks++;
        if (flat_board() !== '0 || bw.lines_cleared !== 3'd1 ||
            bw.lines_total !== 10'd1) begin
            errors++;
            $display("FAIL single_result board=%h lc=%0d lt=%0d want 0 1 1",
                     flat_board(), bw.lines_cleared, bw.lines_total);
        end
    endtask

    task automatic test_tetris();
        int lat;
        for (int r = 16; r <= 19; r++) fill_row9(r);
        checks++;
        if (flat_board() !== (at(16, 10'h1FF) | at(17, 10'h1FF) |
                              at(18, 10'h1FF) | at(19, 10'h1FF))) begin
            errors++;
            $display("FAIL tetris_setup board=%h", flat_board());
        end
        do_lock(9, 16, 9, 17, 9, 18, 9, 19, lat);
        checks++;
        if (lat !== 29) begin
            errors++;
            $display("FAIL tetris_latency got %0d want 29", lat);
        end
        checks++;
        if (flat_board() !== '0 || bw.lines_cleared !== 3'd4 ||
            bw.lines_total !== 10'd5 || bw.game_over !== 1'b0) begin
            errors++;
            $display("FAIL tetris_result board=%h lc=%0d lt=%0d go=%b want 0 4 5 0",
                     flat_board(), bw.lines_cleared, bw.lines_total,
                     bw.game_over);
        end
    endtask

    task automatic test_nonadjacent();
        int lat;
        logic [199:0] exp;
        fill_row9(19);
        fill_row9(17);
        do_lock(0, 18, 1, 16, 0, 18, 1, 16, lat);
        do_lock(9, 19, 9, 17, 5, 0, 5, 0, lat);
        exp = at(19, 10'h001) | at(18, 10'h002) | at(2, 10'h020);
        checks++;
        if (lat !== 25) begin
            errors++;
            $display("FAIL nonadj_latency got %0d want 25", lat);
        end
        checks++;
        if (flat_board() !== exp) begin
            errors++;
            $display("FAIL nonadj_board got %h want %h", flat_board(), exp);
        end
        checks++;
        if (bw.lines_cleared !== 3'd2 || bw.lines_total !== 10'd7) begin
            errors++;
            $display("FAIL nonadj_count lc=%0d lt=%0d want 2 7",
                     bw.lines_cleared, bw.lines_total);
        end
    endtask

    task automatic test_collision();
        int lat;
        logic [199:0] exp;
        exp = at(19, 10'h001) | at(18, 10'h002) | at(2, 10'h020) |
              at(4, 10'h010);
        do_lock(0, 19, 12, 5, 4, 4, 4, 4, lat);
        checks++;
        if (bw.game_over !== 1'b1 || flat_board() !== exp) begin
            errors++;
            $display("FAIL collision go=%b board=%h want 1 %h",
                     bw.game_over, flat_board(), exp);
        end
        do_lock(7, 7, 7, 7, 7, 7, 7, 7, lat);
        exp = exp | at(7, 10'h080);
        checks++;
        if (lat !== 21 || flat_board() !== exp || bw.game_over !== 1'b1) begin
            errors++;
            $display("FAIL lock_after_over lat=%0d board=%h go=%b want 21 %h 1",
                     lat, flat_board(), bw.game_over, exp);
        end
        @(negedge clk);
        bw.clear_board = 1'b1;
        @(negedge clk);
        bw.clear_board = 1'b0;
        checks++;
        if (flat_board() !== '0 || bw.game_over !== 1'b0 ||
            bw.lines_total !== 10'd0 || bw.lines_cleared !== 3'd0 ||
            bw.busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_board board=%h go=%b lt=%0d lc=%0d busy=%b want 0",
                     flat_board(), bw.game_over, bw.lines_total,
                     bw.lines_cleared, bw.busy);
        end
    endtask

    task automatic test_priority();
        int lat;
        do_lock(2, 10, 2, 10, 2, 10, 2, 10, lat);
        @(negedge clk);
        set_cells(3, 10, 3, 10, 3, 10, 3, 10);
        bw.lock_req = 1'b1;
        bw.clear_board = 1'b1;
        @(negedge clk);
        bw.lock_req = 1'b0;
        bw.clear_board = 1'b0;
        checks++;
        if (bw.busy !== 1'b1 || flat_board() !== at(10, 10'h004)) begin
            errors++;
            $display("FAIL lock_priority busy=%b board=%h want 1 %h",
                     bw.busy, flat_board(), at(10, 10'h004));
        end
        repeat (25) @(negedge clk);
        checks++;
        if (flat_board() !== at(10, 10'h00C)) begin
            errors++;
            $display("FAIL priority_board got %h want %h",
                     flat_board(), at(10, 10'h00C));
        end
    endtask

    task automatic test_ignore_busy();
        int lat;
        logic [199:0] exp;
        @(negedge clk);
        set_cells(0, 0, 0, 0, 0, 0, 0, 0);
        bw.lock_req = 1'b1;
        @(negedge clk);
        bw.lock_req = 1'b0;
        set_cells(9, 9, 9, 9, 9, 9, 9, 9);
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            bw.lock_req    = (n >= 3 && n <= 5);
            bw.clear_board = (n >= 3 && n <= 5);
            @(posedge clk);
            @(negedge clk);
            if (bw.done) begin
                lat = n;
                break;
            end
        end
        bw.lock_req = 1'b0;
        bw.clear_board = 1'b0;
        @(negedge clk);
        exp = at(10, 10'h00C) | at(0, 10'h001);
        checks++;
        if (lat !== 21 || flat_board() !== exp || bw.busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_busy lat=%0d board=%h busy=%b want 21 %h 0",
                     lat, flat_board(), bw.busy, exp);
        end
    endtask

    task automatic test_abort();
        int pulses;
        @(negedge clk);
        set_cells(5, 5, 5, 5, 5, 5, 5, 5);
        bw.lock_req = 1'b1;
        @(negedge clk);
        bw.lock_req = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (bw.busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_midscan busy=%b want 1", bw.busy);
        end
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        checks++;
        if (bw.busy !== 1'b0 || bw.done !== 1'b0 || flat_board() !== '0) begin
            errors++;
            $display("FAIL abort_reset busy=%b done=%b board=%h want 0 0 0",
                     bw.busy, bw.done, flat_board());
        end
        pulses = 0;
        repeat (30) begin
            @(negedge clk);
            if (bw.done) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL abort_no_done got %0d pulses want 0", pulses);
        end
    endtask

    initial begin
        bw.lock_req = 1'b0;
        bw.clear_board = 1'b0;
        set_cells(0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_basic_lock();
        test_single_clear();
        test_tetris();
        test_nonadjacent();
        test_collision();
        test_priority();
        test_ignore_busy();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
